// File: rtl/main_memory_responder_if.sv
// Memory-side refill/write-back bus between the cache controller (master)
// and the block-granular main memory (slave).
interface main_memory_responder_if #(
    parameter int ADDR_WIDTH = 30,
    parameter int BLOCK_SIZE = 128
);
    logic                  read_en_mem;
    logic                  write_en_mem;
    logic [ADDR_WIDTH-1:0] block_addr;
    logic [BLOCK_SIZE-1:0] dirty_block_in;
    logic [BLOCK_SIZE-1:0] data_out_mem;
    logic                  mem_ready;
    logic                  mem_busy;

    modport master (
        output read_en_mem, write_en_mem, block_addr, dirty_block_in,
        input  data_out_mem, mem_ready, mem_busy
    );

    modport slave (
        input  read_en_mem, write_en_mem, block_addr, dirty_block_in,
        output data_out_mem, mem_ready, mem_busy
    );
endinterface

// File: rtl/main_memory_responder.sv
// Block-granular main memory with fixed access latency serving cache refills
// and dirty write-backs; completion is flagged by a one-cycle mem_ready pulse.
//
// state   | meaning
// IDLE    | waiting for a request; write-back wins over refill
// WR_WAIT | latency countdown for a write-back, commits on terminal count
// RD_WAIT | latency countdown for a refill, loads data_out_mem on terminal count
// DONE    | completion seen; wait for the completed enable to drop
module main_memory_responder #(
    parameter int WORD_SIZE       = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int ADDR_WIDTH      = 30,
    parameter int MEM_DEPTH       = 1024,
    parameter int LATENCY         = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    main_memory_responder_if.slave bus
);
    localparam int BLOCK_SIZE = WORD_SIZE * WORDS_PER_BLOCK;
    localparam int IDX_W      = $clog2(MEM_DEPTH);
    localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  op_wr;
    logic [IDX_W-1:0]      lat_idx;
    logic [BLOCK_SIZE-1:0] lat_data;
    logic [BLOCK_SIZE-1:0] data_out_q;
    logic                  ready_q;
    logic                  busy_q;
    logic                  commit;

    logic [BLOCK_SIZE-1:0] mem [MEM_DEPTH];

    // Upper address bits deliberately alias onto the same storage.
    generate
        if (ADDR_WIDTH > IDX_W) begin : g_alias
            wire unused_upper_addr = ^bus.block_addr[ADDR_WIDTH-1:IDX_W];
        end
    endgenerate

    assign commit = (state == WR_WAIT) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[lat_idx] <= lat_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            op_wr      <= 1'b0;
            lat_idx    <= '0;
            lat_data   <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.write_en_mem) begin
                        lat_idx  <= bus.block_addr[IDX_W-1:0];
                        lat_data <= bus.dirty_block_in;
                        cnt      <= CNT_W'(LATENCY - 1);
                        op_wr    <= 1'b1;
                        busy_q   <= 1'b1;
                        state    <= WR_WAIT;
                    end else if (bus.read_en_mem) begin
                        lat_idx  <= bus.block_addr[IDX_W-1:0];
                        cnt      <= CNT_W'(LATENCY - 1);
                        op_wr    <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= RD_WAIT;
                    end
                end
                WR_WAIT, RD_WAIT: begin
                    if (cnt == '0) begin
                        if (state == RD_WAIT) begin
                            data_out_q <= mem[lat_idx];
                        end
                        ready_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    // Only the enable of the completed operation releases DONE.
                    if (op_wr ? !bus.write_en_mem : !bus.read_en_mem) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_out_mem = data_out_q;
    assign bus.mem_ready    = ready_q;
    assign bus.mem_busy     = busy_q;
endmodule
